// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// stage enable/kill masks and default sizes.
package hazard_pkg;

    localparam int AW_DEF   = 4;
    localparam int NREG_DEF = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bit i of a mask refers to pipeline stage i+1
    localparam logic [3:0] EN_ALL     = 4'b1111;
    localparam logic [3:0] EN_STALL   = 4'b1100;
    localparam logic [3:0] EN_NONE    = 4'b0000;
    localparam logic [3:0] KILL_NONE  = 4'b0000;
    localparam logic [3:0] KILL_STALL = 4'b0100;
    localparam logic [3:0] KILL_FLUSH = 4'b0111;
    localparam logic [3:0] KILL_ALL   = 4'b1111;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write counters (2 bits each). Produces the
// effective-busy view (with same-cycle retire bypass), saturation and
// zero flags used by the controller.
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            clr,
    input  logic            inc_en,
    input  logic [AW-1:0]   inc_idx,
    input  logic            dec_en,
    input  logic [AW-1:0]   dec_idx,
    output logic [NREG-1:0] eb,
    output logic [NREG-1:0] sat,
    output logic [NREG-1:0] zero,
    output logic [NREG-1:0] busy
);

    logic [1:0]      cnt_r     [NREG];
    logic [1:0]      cnt_nxt_s [NREG];
    logic [NREG-1:0] inc_hit_s;
    logic [NREG-1:0] ret_hit_s;
    logic [NREG-1:0] dec_hit_s;

    // Next counter values and the flags derived from the current counters
    always_comb begin
        inc_hit_s = {NREG{1'b0}};
        ret_hit_s = {NREG{1'b0}};
        dec_hit_s = {NREG{1'b0}};
        eb        = {NREG{1'b0}};
        sat       = {NREG{1'b0}};
        zero      = {NREG{1'b0}};
        busy      = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt_s[r] = cnt_r[r];
            inc_hit_s[r] = inc_en && (inc_idx == AW'(r));
            ret_hit_s[r] = dec_en && (dec_idx == AW'(r));
            // A retire of an idle register never underflows the counter
            dec_hit_s[r] = ret_hit_s[r] && (cnt_r[r] != 2'd0);
            if (clr) begin
                cnt_nxt_s[r] = 2'd0;
            end else if (inc_hit_s[r] && !dec_hit_s[r] && (cnt_r[r] != 2'd3)) begin
                cnt_nxt_s[r] = cnt_r[r] + 2'd1;
            end else if (dec_hit_s[r] && !inc_hit_s[r]) begin
                cnt_nxt_s[r] = cnt_r[r] - 2'd1;
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
            // The last outstanding write retiring this cycle no longer blocks readers
            eb[r]   = (cnt_r[r] != 2'd0) && !(ret_hit_s[r] && (cnt_r[r] == 2'd1));
            sat[r]  = (cnt_r[r] == 2'd3) && !ret_hit_s[r];
            zero[r] = (cnt_r[r] == 2'd0);
            busy[r] = (cnt_r[r] != 2'd0);
        end
    end

    // Counter storage
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 4-stage core: stalls decode on
// RAW / scoreboard-saturation hazards and flushes younger stages after a
// taken branch resolved in stage 4.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int NREG      = NREG_DEF,
    parameter int AW        = AW_DEF,
    parameter int PCW       = 16,
    parameter int FLUSH_CYC = 3
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            ISSUE_VALID,
    input  logic            ISSUE_RD_EN,
    input  logic [AW-1:0]   ISSUE_RD,
    input  logic            ISSUE_RS_EN,
    input  logic [AW-1:0]   ISSUE_RS1,
    input  logic [AW-1:0]   ISSUE_RS2,
    input  logic            RETIRE_EN,
    input  logic [AW-1:0]   RETIRE_RD,
    input  logic            BR_TAKEN,
    input  logic [PCW-1:0]  BR_TARGET,
    output logic            ISSUE_ACK,
    output logic [3:0]      STAGE_EN,
    output logic [3:0]      STAGE_KILL,
    output logic            PC_LOAD,
    output logic [PCW-1:0]  PC_TARGET,
    output logic [NREG-1:0] BUSY_MAP,
    output logic [15:0]     STALL_CNT,
    output logic            ERR
);

    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYC - 1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [FCW-1:0]  flush_cnt_r;
    logic [15:0]     stall_cnt_r;
    logic            err_r;
    logic            pc_load_r;
    logic [PCW-1:0]  pc_target_r;

    logic            active_s;
    logic            br_go_s;
    logic            dec_req_s;
    logic            hazard_s;
    logic            ack_s;
    logic            inc_en_s;
    logic [3:0]      en_s;
    logic [3:0]      kill_s;
    logic [NREG-1:0] eb_s;
    logic [NREG-1:0] sat_s;
    logic [NREG-1:0] zero_s;
    logic [NREG-1:0] busy_s;

    // RUN and STALL both accept branches and retires; FLUSH ignores them
    assign active_s  = (state_r != FLUSH);
    assign br_go_s   = active_s && BR_TAKEN;
    assign dec_req_s = active_s && RETIRE_EN && !BR_TAKEN;
    assign inc_en_s  = ack_s && ISSUE_RD_EN;

    assign hazard_s = ISSUE_VALID &&
                      ((ISSUE_RS_EN && (eb_s[ISSUE_RS1] || eb_s[ISSUE_RS2])) ||
                       (ISSUE_RD_EN && sat_s[ISSUE_RD]));

    hazard_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .clr     (br_go_s),
        .inc_en  (inc_en_s),
        .inc_idx (ISSUE_RD),
        .dec_en  (dec_req_s),
        .dec_idx (RETIRE_RD),
        .eb      (eb_s),
        .sat     (sat_s),
        .zero    (zero_s),
        .busy    (busy_s)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a branch beats any hazard; FLUSH lasts FLUSH_CYC cycles
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN, STALL: begin
                if (BR_TAKEN) begin
                    state_nxt_s = FLUSH;
                end else if (hazard_s) begin
                    state_nxt_s = STALL;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == {FCW{1'b0}}) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // FSM outputs: stage masks and issue acceptance, forced safe while in reset
    always_comb begin
        ack_s  = 1'b0;
        en_s   = EN_NONE;
        kill_s = KILL_ALL;
        if (!RSTN) begin
            ack_s  = 1'b0;
            en_s   = EN_NONE;
            kill_s = KILL_ALL;
        end else begin
            case (state_r)
                RUN, STALL: begin
                    if (hazard_s) begin
                        ack_s  = 1'b0;
                        en_s   = EN_STALL;
                        kill_s = KILL_STALL;
                    end else begin
                        // An instruction issued alongside a branch is discarded by the flush
                        ack_s  = ISSUE_VALID && !BR_TAKEN;
                        en_s   = EN_ALL;
                        kill_s = KILL_NONE;
                    end
                end
                FLUSH: begin
                    ack_s  = 1'b0;
                    en_s   = EN_ALL;
                    kill_s = KILL_FLUSH;
                end
                default: begin
                    ack_s  = 1'b0;
                    en_s   = EN_NONE;
                    kill_s = KILL_ALL;
                end
            endcase
        end
    end

    // Flush bubble counter: loaded on branch, counts down while flushing
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            flush_cnt_r <= {FCW{1'b0}};
        end else if (br_go_s) begin
            flush_cnt_r <= FLUSH_LOAD;
        end else if ((state_r == FLUSH) && (flush_cnt_r != {FCW{1'b0}})) begin
            flush_cnt_r <= flush_cnt_r - {{(FCW-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Stall statistics and sticky retire-underflow error
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt_r <= 16'd0;
            err_r       <= 1'b0;
        end else begin
            if (active_s && !BR_TAKEN && hazard_s) begin
                stall_cnt_r <= sat_inc16(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (dec_req_s && zero_s[RETIRE_RD]) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // PC redirect: one-cycle load pulse and captured target
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_load_r   <= 1'b0;
            pc_target_r <= {PCW{1'b0}};
        end else if (br_go_s) begin
            pc_load_r   <= 1'b1;
            pc_target_r <= BR_TARGET;
        end else begin
            pc_load_r   <= 1'b0;
            pc_target_r <= pc_target_r;
        end
    end

    assign ISSUE_ACK  = ack_s;
    assign STAGE_EN   = en_s;
    assign STAGE_KILL = kill_s;
    assign PC_LOAD    = pc_load_r;
    assign PC_TARGET  = pc_target_r;
    assign BUSY_MAP   = RSTN ? busy_s : {NREG{1'b0}};
    assign STALL_CNT  = stall_cnt_r;
    assign ERR        = err_r;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline sequencing controller for the 4-stage 16-bit core: tracks in-flight register writes in a per-register scoreboard, stalls decode on RAW or scoreboard-saturation hazards, and flushes younger stages on a taken branch resolved at writeback.
- Sits beside the PC/fetch logic and drives its stage advance/bubble controls and PC redirect.

## Interface
Parameters:
- NREG, 16, architectural registers
- AW, 4, register address width
- PCW, 16, PC width
- FLUSH_CYC, 3, cycles of bubble injection after a taken branch (≥1)

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- ISSUE_VALID  in  1  decode (stage 2) holds an instruction
- ISSUE_RD_EN / ISSUE_RD  in  1 / AW  instruction writes register ISSUE_RD
- ISSUE_RS_EN / ISSUE_RS1 / ISSUE_RS2  in  1 / AW / AW  instruction reads sources
- RETIRE_EN / RETIRE_RD  in  1 / AW  stage 4 completes a register write
- BR_TAKEN / BR_TARGET  in  1 / PCW  taken branch resolved in stage 4
- ISSUE_ACK  out  1  decode instruction accepted this cycle
- STAGE_EN  out  4  bit i: stage i+1 advances
- STAGE_KILL  out  4  bit i: stage i+1 loads a bubble
- PC_LOAD / PC_TARGET  out  1 / PCW  PC redirect
- BUSY_MAP  out  NREG  bit r set when cnt[r]≠0
- STALL_CNT  out  16  saturating count of STALL cycles
- ERR  out  1  sticky: retire to a register with cnt=0 outside FLUSH

## Operation
- Scoreboard: 2-bit counter cnt[r] per register, all 0 at reset.
- Effective busy: eb[r] = (cnt[r]≠0) and not (RETIRE_EN and RETIRE_RD=r and cnt[r]=1); same-cycle retire bypasses the hazard.
- hazard = ISSUE_VALID and ((RS_EN and (eb[RS1] or eb[RS2])) or (RD_EN and cnt[RD]=3 and no same-cycle retire of RD)).
- FSM states RUN, STALL, FLUSH; reset → RUN.
- RUN/STALL, BR_TAKEN=1: next FLUSH, flush counter ← FLUSH_CYC−1, capture BR_TARGET, all cnt ← 0 (the same-cycle retire is ignored); takes priority over everything.
- RUN/STALL, hazard: next STALL; STAGE_EN=4'b1100, STAGE_KILL=4'b0100, ISSUE_ACK=0, STALL_CNT+1 (saturating at 16'hFFFF).
- RUN/STALL, no hazard: next RUN; STAGE_EN=4'b1111, STAGE_KILL=4'b0000, ISSUE_ACK=ISSUE_VALID.
- Accepted issue with RD_EN: cnt[RD]+1. Retire: cnt[RD]−1. Both on the same register: net unchanged.
- FLUSH: STAGE_EN=4'b1111, STAGE_KILL=4'b0111, ISSUE_ACK=0; BR_TAKEN and RETIRE_EN are ignored; counter decrements each cycle; at 0, next state is RUN.
- Retire with cnt=0 in RUN/STALL: counter stays 0, ERR←1.

## Timing
- ISSUE_ACK, STAGE_EN, STAGE_KILL: combinational from current state, registered cnt and current inputs (same-cycle stall).
- State, cnt, STALL_CNT, ERR, PC_LOAD, PC_TARGET: registered.
- PC_LOAD: one-cycle pulse in the first FLUSH cycle, i.e. one cycle after BR_TAKEN.
- PC_TARGET holds its captured value until the next branch.
- Stall release: the cycle the last blocking retire is seen, ISSUE_ACK=1 (zero-cycle bypass).
- Reset (async, any state, including mid-FLUSH):
  - State RUN, cnt all 0, STALL_CNT=0, ERR=0, PC_LOAD=0, PC_TARGET=0.
  - While RSTN=0: STAGE_EN=0, STAGE_KILL=4'b1111, ISSUE_ACK=0, BUSY_MAP=0.

## Structure
- Shared package hazard_pkg: state enum (RUN=2'd0, STALL=2'd1, FLUSH=2'd2), stage-mask constants (EN_ALL, EN_STALL, KILL_STALL, KILL_FLUSH), AW/NREG defaults.
- Sub-module hazard_scoreboard: holds the counters, the inc/dec/clear ports, eb/BUSY_MAP and saturation flags. FSM, masks and counters stay in hazard_ctrl.

## Test plan
- Issue RD=5 (ack), next cycle issue RS1=5 → STALL, STAGE_EN=4'b1100, KILL=4'b0100, STALL_CNT increments per cycle; RETIRE_RD=5 → same-cycle ISSUE_ACK=1, next RUN.
- Four issues writing R3 with no retire → the fourth stalls (cnt=3); a retire of R3 in the same cycle lets it issue, cnt stays 3.
- BR_TAKEN with BR_TARGET=16'h0040 during STALL → next cycle PC_LOAD=1, PC_TARGET=16'h0040, KILL=4'b0111 for 3 cycles, BUSY_MAP=0, then RUN.
- Same-cycle issue RD=7 and retire RD=7 with cnt[7]=1 → cnt[7] stays 1, no stall for a dependent reading R7 that cycle.
- Retire R9 with cnt=0 in RUN → ERR=1 and sticky; the same retire during FLUSH → ERR unchanged.
- RSTN low mid-FLUSH → outputs at reset values immediately; after release, state RUN and PC_LOAD never pulses.
